otp_stream_ctrl: RTL and testbench
==================================

Name: otp_stream_ctrl

Overview:
Sequencing controller for the one-time-pad XOR datapath. Holds a loaded key and accepts a framed stream of M-bit words over valid/ready. It expands the key to M bits and XORs each word through a registered output stage. The key is rotated per word so consecutive words see different pads. Encryption and decryption are the same operation; the block sits between a word source and sink in the cipher subsystem.

Parameters:
N, 2, key width in bits (N >= 1)
M, 6, data word width in bits (M >= 1)
ROT, 1, left-rotate amount applied to the working key after each accepted word; 0 gives a static key; taken mod N
CW, 8, width of word counter and frame length

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
key_valid  in  1  key offer
key_in  in  N  key value
key_ready  out  1  key accepted when key_valid && key_ready
in_valid  in  1  input word valid
in_data  in  M  plaintext or ciphertext word
in_last  in  1  marks final word of frame
in_ready  out  1  input word accepted when in_valid && in_ready
out_valid  out  1  output word valid
out_data  out  M  XOR result
out_last  out  1  copy of in_last for this word
out_ready  in  1  sink accepts when out_valid && out_ready
busy  out  1  high in state RUN
word_count  out  CW  words accepted in current frame, saturating at 2^CW-1
frame_len  out  CW  word_count value including last word, latched on last-word accept
err_nokey  out  1  sticky: in_valid seen while state NOKEY

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=NOKEY, key_base=0, key_cur=0, out_valid=0, out_data=0, out_last=0, word_count=0, frame_len=0, err_nokey=0.
- Reset asserted mid-frame discards the key and any pending output, and returns to NOKEY.
- States:
  - NOKEY: no key loaded.
  - IDLE: key loaded, between frames.
  - RUN: inside a frame.
- Transitions:
  - NOKEY -> IDLE on key accept.
  - IDLE -> RUN on accept of a word with in_last=0.
  - IDLE stays IDLE on accept of a single-word frame (in_last=1).
  - RUN -> IDLE on accept of a word with in_last=1.
- Key handshake:
  - key_ready = (state != RUN). key_valid is ignored in RUN.
  - On key accept: key_base <= key_in, key_cur <= key_in, err_nokey <= 0.
- Key expansion (sub-module): ks[i] = key_cur[i mod N] for i in 0..M-1.
- Input handshake: in_ready = (state != NOKEY) && !(key_valid && key_ready) && (!out_valid || out_ready). A key offer in IDLE takes priority; the input waits one cycle.
- Accept timing:
  - On input accept: out_data <= in_data ^ ks, out_last <= in_last, out_valid <= 1 on the next edge. Latency is 1 cycle.
  - Throughput is 1 word/cycle while out_ready=1.
- Output retirement: when out_valid && out_ready with no new accept, out_valid <= 0. out_data is held stable while out_valid && !out_ready.
- Key rotation:
  - After a non-last accept: key_cur <= rotl(key_cur, ROT mod N).
  - After a last accept: key_cur <= key_base, so every frame restarts at the base pad.
- Counter:
  - word_count increments per accept and saturates, never wrapping.
  - On a last accept: frame_len <= saturated count including that word, and word_count <= 0.
- err_nokey: set when in_valid=1 in NOKEY; cleared only by key accept or reset.

Decomposition:
- Shared package otp_pkg:
  - State encoding localparams: NOKEY=2'd0, IDLE=2'd1, RUN=2'd2.
  - Default N/M constants shared with the OTP datapath.
- Sub-module otp_keystream: combinational key_cur[N] -> ks[M] replication. Reused by the existing pad datapath.
- Rotation, FSM, counter and output register live in otp_stream_ctrl.

Test Plan:
1. Reset, then drive in_valid=1 with no key -> in_ready=0, err_nokey=1. Then key_in=01 accepted -> err_nokey=0, state IDLE.
2. Key 01, N=2, M=6, ROT=1, single word 101010 with last=1 -> next cycle out_data=111111, out_last=1, frame_len=1, key_cur back to 01.
3. Frame of words 101010, 101010, 101010 (last on the third), out_ready=1 -> outputs 111111, 000000, 111111 (key 01, 10, 01). frame_len=3, busy high until the third accept.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data held. Releasing out_ready -> no word lost or duplicated, correct order.
5. key_valid during RUN -> key_ready=0 and the key is unchanged. The same key_valid and in_valid together in IDLE -> key taken, word taken the following cycle with the new key.
6. Assert rst mid-frame after 2 words -> out_valid=0, state NOKEY, word_count=0. A subsequent word is refused until a new key is loaded.

Source files
------------

// File: rtl/otp_pkg.sv
// Shared definitions for the one-time-pad stream controller and pad datapath.
package otp_pkg;

    // Default key and word widths shared with the OTP datapath.
    localparam int unsigned OtpKeyW  = 2;
    localparam int unsigned OtpWordW = 6;

    // Controller state encoding.
    typedef enum logic [1:0] {
        StNokey = 2'd0,
        StIdle  = 2'd1,
        StRun   = 2'd2
    } otp_state_e;

endpackage

// File: rtl/otp_keystream.sv
// Expands an N-bit key to an M-bit pad by cyclic replication.
module otp_keystream #(
    parameter int unsigned N = 2,
    parameter int unsigned M = 6
) (
    input  logic [N-1:0] key_cur,
    output logic [M-1:0] ks
);

    // Pad bit i repeats key bit (i mod N).
    for (genvar i = 0; i < M; i++) begin : g_ks
        assign ks[i] = key_cur[i % N];
    end

endmodule

// File: rtl/otp_stream_ctrl.sv
// Framed valid/ready XOR stream controller with per-word key rotation.
module otp_stream_ctrl
    import otp_pkg::*;
#(
    parameter int unsigned N   = OtpKeyW,
    parameter int unsigned M   = OtpWordW,
    parameter int unsigned ROT = 1,
    parameter int unsigned CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [N-1:0]  key_in,
    output logic          key_ready,
    input  logic          in_valid,
    input  logic [M-1:0]  in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output logic [M-1:0]  out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic [CW-1:0] word_count,
    output logic [CW-1:0] frame_len,
    output logic          err_nokey
);

    localparam int unsigned RotAmt = ROT % N;

    otp_state_e    state_q, state_d;
    logic [N-1:0]  key_base_q, key_base_d;
    logic [N-1:0]  key_cur_q, key_cur_d;
    logic          out_valid_q, out_valid_d;
    logic [M-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [CW-1:0] word_count_q, word_count_d;
    logic [CW-1:0] frame_len_q, frame_len_d;
    logic          err_nokey_q, err_nokey_d;

    logic [M-1:0]  ks;
    logic [N-1:0]  key_rot;
    logic [CW-1:0] cnt_inc;
    logic          key_acc;
    logic          in_acc;

    otp_keystream #(
        .N (N),
        .M (M)
    ) u_keystream (
        .key_cur (key_cur_q),
        .ks      (ks)
    );

    // Handshakes: a key offer outside RUN wins over a pending input word.
    always_comb begin
        key_ready = (state_q != StRun);
        key_acc   = key_valid && key_ready;
        in_ready  = (state_q != StNokey) && !key_acc && (!out_valid_q || out_ready);
        in_acc    = in_valid && in_ready;
        // With RotAmt == 0 the right shift clears everything and the key stays static.
        key_rot   = (key_cur_q << RotAmt) | (key_cur_q >> (N - RotAmt));
        cnt_inc   = (word_count_q == {CW{1'b1}}) ? word_count_q : word_count_q + CW'(1);
    end

    // Next-state for FSM, key registers, counters and output stage.
    always_comb begin
        state_d      = state_q;
        key_base_d   = key_base_q;
        key_cur_d    = key_cur_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        word_count_d = word_count_q;
        frame_len_d  = frame_len_q;
        err_nokey_d  = err_nokey_q;

        if (key_acc) begin
            key_base_d  = key_in;
            key_cur_d   = key_in;
            err_nokey_d = 1'b0;
            if (state_q == StNokey) begin
                state_d = StIdle;
            end
        end else if (in_valid && (state_q == StNokey)) begin
            err_nokey_d = 1'b1;
        end

        if (in_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ ks;
            out_last_d  = in_last;
            if (in_last) begin
                // Every frame restarts from the base pad.
                key_cur_d    = key_base_q;
                word_count_d = '0;
                frame_len_d  = cnt_inc;
                state_d      = StIdle;
            end else begin
                key_cur_d    = key_rot;
                word_count_d = cnt_inc;
                state_d      = StRun;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StNokey;
            key_base_q   <= '0;
            key_cur_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            word_count_q <= '0;
            frame_len_q  <= '0;
            err_nokey_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_base_q   <= key_base_d;
            key_cur_q    <= key_cur_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            word_count_q <= word_count_d;
            frame_len_q  <= frame_len_d;
            err_nokey_q  <= err_nokey_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q == StRun);
    assign word_count = word_count_q;
    assign frame_len  = frame_len_q;
    assign err_nokey  = err_nokey_q;

endmodule

// File: tb/tb_otp_stream_ctrl.sv
// Directed self-checking bench for otp_stream_ctrl (N=2, M=6, ROT=1, CW=8).
module tb_otp_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [1:0] key_in = '0;
    logic       key_ready;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [5:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       busy;
    logic [7:0] word_count;
    logic [7:0] frame_len;
    logic       err_nokey;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    otp_stream_ctrl #(
        .N   (2),
        .M   (6),
        .ROT (1),
        .CW  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .word_count (word_count),
        .frame_len  (frame_len),
        .err_nokey  (err_nokey)
    );

    // Advance one clock; inputs change and outputs are sampled 2 units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 6'd0) begin n_fail++; $display("FAIL rst_out_data got %b want 000000", out_data); end
        n_checks++; if (word_count !== 8'd0) begin n_fail++; $display("FAIL rst_word_count got %0d want 0", word_count); end
        n_checks++; if (frame_len !== 8'd0) begin n_fail++; $display("FAIL rst_frame_len got %0d want 0", frame_len); end
        n_checks++; if (err_nokey !== 1'b0) begin n_fail++; $display("FAIL rst_err_nokey got %b want 0", err_nokey); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        rst = 1'b0;
        tick();
        // No key: input refused and the error flag latches.
        in_valid = 1'b1; in_data = 6'b101010; in_last = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL nokey_in_ready got %b want 0", in_ready); end
        n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL nokey_key_ready got %b want 1", key_ready); end
        tick();
        n_checks++; if (err_nokey !== 1'b1) begin n_fail++; $display("FAIL nokey_err_set got %b want 1", err_nokey); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nokey_no_output got %b want 0", out_valid); end
        in_valid = 1'b0;
        key_valid = 1'b1; key_in = 2'b01;
        tick();
        key_valid = 1'b0;
        #1;
        n_checks++; if (err_nokey !== 1'b0) begin n_fail++; $display("FAIL key_err_clear got %b want 0", err_nokey); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 6'b101010; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 6'b111111) begin n_fail++; $display("FAIL single_data got %b want 111111", out_data); end
        n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL single_last got %b want 1", out_last); end
        n_checks++; if (frame_len !== 8'd1) begin n_fail++; $display("FAIL single_frame_len got %0d want 1", frame_len); end
        n_checks++; if (word_count !== 8'd0) begin n_fail++; $display("FAIL single_word_count got %0d want 0", word_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b want 0", busy); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_retire got %b want 0", out_valid); end
    endtask

    task automatic test_frame();
        logic [5:0] exp_data [3];
        exp_data[0] = 6'b111111; exp_data[1] = 6'b000000; exp_data[2] = 6'b111111;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 6'b101010; in_last = (i == 2);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL frame_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            n_checks++; if (out_data !== exp_data[i]) begin n_fail++; $display("FAIL frame_data[%0d] got %b want %b", i, out_data, exp_data[i]); end
            n_checks++; if (out_last !== (i == 2)) begin n_fail++; $display("FAIL frame_last[%0d] got %b want %b", i, out_last, (i == 2)); end
            n_checks++; if (busy !== (i != 2)) begin n_fail++; $display("FAIL frame_busy[%0d] got %b want %b", i, busy, (i != 2)); end
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++; if (frame_len !== 8'd3) begin n_fail++; $display("FAIL frame_len got %0d want 3", frame_len); end
        n_checks++; if (word_count !== 8'd0) begin n_fail++; $display("FAIL frame_word_count got %0d want 0", word_count); end
        tick();
    endtask

    task automatic test_backpressure();
        // A with key 01, B with key 10, C (last) with key 01.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 6'b000000; in_last = 1'b0;
        tick();
        in_data = 6'b110011;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, in_ready); end
            n_checks++; if (out_data !== 6'b010101) begin n_fail++; $display("FAIL bp_hold[%0d] got %b want 010101", k, out_data); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", k, out_valid); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_data !== 6'b011001) begin n_fail++; $display("FAIL bp_word_b got %b want 011001", out_data); end
        n_checks++; if (word_count !== 8'd2) begin n_fail++; $display("FAIL bp_count got %0d want 2", word_count); end
        in_data = 6'b000011; in_last = 1'b1;
        tick();
        n_checks++; if (out_data !== 6'b010110) begin n_fail++; $display("FAIL bp_word_c got %b want 010110", out_data); end
        n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL bp_last got %b want 1", out_last); end
        n_checks++; if (frame_len !== 8'd3) begin n_fail++; $display("FAIL bp_frame_len got %0d want 3", frame_len); end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_key_priority();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 6'b000000; in_last = 1'b0;
        tick();
        n_checks++; if (out_data !== 6'b010101) begin n_fail++; $display("FAIL kp_first got %b want 010101", out_data); end
        // In RUN the key offer is ignored; the word uses the rotated key 10.
        key_valid = 1'b1; key_in = 2'b11; in_last = 1'b1;
        #1;
        n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL kp_run_key_ready got %b want 0", key_ready); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kp_run_in_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_data !== 6'b101010) begin n_fail++; $display("FAIL kp_run_data got %b want 101010", out_data); end
        // In IDLE the key wins and the word waits a cycle.
        #1;
        n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL kp_idle_key_ready got %b want 1", key_ready); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL kp_idle_in_ready got %b want 0", in_ready); end
        tick();
        key_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kp_word_waits got %b want 0", out_valid); end
        tick();
        n_checks++; if (out_data !== 6'b111111) begin n_fail++; $display("FAIL kp_new_key got %b want 111111", out_data); end
        n_checks++; if (frame_len !== 8'd1) begin n_fail++; $display("FAIL kp_frame_len got %0d want 1", frame_len); end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        in_valid = 1'b1; in_data = 6'b000000; in_last = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        n_checks++; if (word_count !== 8'd2) begin n_fail++; $display("FAIL mid_count got %0d want 2", word_count); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        n_checks++; if (word_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_count got %0d want 0", word_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_last = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_refuse got %b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_out got %b want 0", out_valid); end
        n_checks++; if (err_nokey !== 1'b1) begin n_fail++; $display("FAIL mid_err got %b want 1", err_nokey); end
        in_valid = 1'b0;
        key_valid = 1'b1; key_in = 2'b10;
        tick();
        key_valid = 1'b0;
        in_valid = 1'b1; in_data = 6'b000000; in_last = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rekey_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++; if (out_data !== 6'b101010) begin n_fail++; $display("FAIL mid_rekey_data got %b want 101010", out_data); end
        n_checks++; if (err_nokey !== 1'b0) begin n_fail++; $display("FAIL mid_rekey_err got %b want 0", err_nokey); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_frame();
        test_backpressure();
        test_key_priority();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
